up_input_stage: RTL and testbench

Front-end conditioning stage that sits directly upstream of the 8-bit microprocessor top level and drives its `Enter` and `Input` ports. It synchronises the raw `Enter` push-button and 8 data switches, debounces the button with a press/release state machine, and latches the switch byte once per accepted press. The latched byte is held stable for the processor's INPUT instruction.

---
 rtl/up_input_stage_if.sv | 12 +
 rtl/up_input_stage.sv | 103 ++++++++++
 tb/tb_up_input_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/up_input_stage_if.sv
// Button/switch inputs and Enter/Input outputs exchanged between the
// input conditioning stage and its surroundings.
interface up_input_stage_if;
    logic       Button;
    logic [7:0] Switch;
    logic       Enter;
    logic       EnterPulse;
    logic [7:0] Input;

    modport master (input Button, Switch, output Enter, EnterPulse, Input);
    modport slave  (output Button, Switch, input Enter, EnterPulse, Input);
endinterface

// File: rtl/up_input_stage.sv
// Synchronises the Enter button and data switches, debounces the button and
// latches the switch byte once per accepted press.
module up_input_stage #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic             CLOCK,
    input  logic             RESET,
    up_input_stage_if.master io
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       btn_sync;
    logic [7:0]       sw_m, sw_s;
    logic             btn_s;
    logic             enter_nx, pulse_nx, latch;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            btn_sync <= '0;
            sw_m     <= '0;
            sw_s     <= '0;
        end else begin
            btn_sync <= {btn_sync[0], io.Button};
            sw_m     <= io.Switch;
            sw_s     <= sw_m;
        end
    end

    assign btn_s = btn_sync[1];

    // The btn_s test is evaluated before the counter test, so a level flip on
    // the terminal count cycle still rejects the press/release.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = 1'b0;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    pulse_nx = 1'b1;
                    latch    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        enter_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            io.Enter      <= 1'b0;
            io.EnterPulse <= 1'b0;
            io.Input      <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            io.Enter      <= enter_nx;
            io.EnterPulse <= pulse_nx;
            if (latch) io.Input <= sw_s;
        end
    end
endmodule

// File: tb/tb_up_input_stage.sv
// Scoreboard bench for up_input_stage with DB_CYCLES=4: directed button
// patterns queue expected (data, cycle) pulses checked by an output monitor.
module tb_up_input_stage;
    localparam int DB = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    up_input_stage_if uif ();

    up_input_stage #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .io   (uif)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic expect_pulse(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Output monitor: every EnterPulse consumes one scoreboard entry.
    logic pulse_d    = 1'b0;
    int   last_pulse = -1;
    always @(negedge CLOCK) begin
        exp_t e;
        if (!RESET) last_pulse = -1;
        if (pulse_d) chk("pulse_width", int'(uif.EnterPulse), 0);
        pulse_d = uif.EnterPulse;
        if (uif.EnterPulse === 1'b1) begin
            pulses++;
            if (last_pulse >= 0) chk("pulse_spacing_ge12", int'(cyc - last_pulse >= 12), 1);
            last_pulse = cyc;
            chk("pulse_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_input", int'(uif.Input), int'(e.data));
            end
        end
    end

    logic pat_press [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic pat_rel   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int e0;
        int pb;
        int bad;

        uif.Button = 1'b0;
        uif.Switch = 8'h00;
        step(3);
        chk("reset_enter", int'(uif.Enter), 0);
        chk("reset_pulse", int'(uif.EnterPulse), 0);
        chk("reset_input", int'(uif.Input), 0);
        RESET = 1'b1;
        step(3);

        // Clean press, switches move while held, 100-cycle hold
        pb = pulses;
        uif.Switch = 8'h3C;
        uif.Button = 1'b1;
        e0 = cyc + 1;
        expect_pulse(8'h3C, e0 + DB + 2);
        step(6);
        chk("clean_enter_before", int'(uif.Enter), 0);
        step(1);
        chk("clean_enter_rise", int'(uif.Enter), 1);
        chk("clean_input", int'(uif.Input), 8'h3C);
        uif.Switch = 8'hFF;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (uif.Enter !== 1'b1) bad++;
        end
        chk("hold_enter_low_cycles", bad, 0);
        chk("hold_input_kept", int'(uif.Input), 8'h3C);
        chk("hold_single_pulse", pulses - pb, 1);

        // Clean release
        uif.Button = 1'b0;
        step(6);
        chk("release_enter_before", int'(uif.Enter), 1);
        step(1);
        chk("release_enter_fall", int'(uif.Enter), 0);
        step(4);

        // Press bounce 1,1,0,1,1,1,1,1,1
        pb = pulses;
        uif.Switch = 8'h5A;
        e0 = cyc + 1;
        expect_pulse(8'h5A, e0 + 9);
        for (int i = 0; i < 9; i++) begin
            uif.Button = pat_press[i];
            step(1);
        end
        chk("pbounce_enter_before", int'(uif.Enter), 0);
        step(1);
        chk("pbounce_enter_rise", int'(uif.Enter), 1);
        step(3);
        chk("pbounce_single_pulse", pulses - pb, 1);

        // Release bounce 0,0,1,0,0,0,0,0
        pb = pulses;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            uif.Button = pat_rel[i];
            step(1);
            if (uif.Enter !== 1'b1) bad++;
        end
        step(1);
        if (uif.Enter !== 1'b1) bad++;
        chk("rbounce_enter_held", bad, 0);
        step(1);
        chk("rbounce_enter_fall", int'(uif.Enter), 0);
        chk("rbounce_no_pulse", pulses - pb, 0);
        step(4);

        // Back-to-back: 8 high, 8 low, 8 high
        pb = pulses;
        uif.Switch = 8'h11;
        uif.Button = 1'b1;
        e0 = cyc + 1;
        expect_pulse(8'h11, e0 + 6);
        expect_pulse(8'h22, e0 + 22);
        step(8);
        uif.Button = 1'b0;
        uif.Switch = 8'h22;
        step(8);
        uif.Button = 1'b1;
        step(8);
        uif.Button = 1'b0;
        step(10);
        chk("b2b_two_pulses", pulses - pb, 2);
        chk("b2b_enter_low", int'(uif.Enter), 0);
        chk("b2b_input", int'(uif.Input), 8'h22);

        // Reset asserted while PRESSED, button kept high through it
        uif.Switch = 8'hA5;
        uif.Button = 1'b1;
        e0 = cyc + 1;
        expect_pulse(8'hA5, e0 + 6);
        step(8);
        chk("pre_reset_input", int'(uif.Input), 8'hA5);
        chk("pre_reset_enter", int'(uif.Enter), 1);
        RESET = 1'b0;
        #1;
        chk("async_reset_enter", int'(uif.Enter), 0);
        chk("async_reset_pulse", int'(uif.EnterPulse), 0);
        chk("async_reset_input", int'(uif.Input), 0);
        step(2);
        RESET = 1'b1;
        uif.Switch = 8'hC3;
        e0 = cyc + 1;
        expect_pulse(8'hC3, e0 + 6);
        step(6);
        chk("post_reset_enter_before", int'(uif.Enter), 0);
        step(1);
        chk("post_reset_enter_rise", int'(uif.Enter), 1);
        chk("post_reset_input", int'(uif.Input), 8'hC3);
        step(3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
